pipe_ctrl: RTL

Parametrised pipeline sequencing and hazard-control unit for the CPU core. It owns the run/drain/halt state machine, per-stage valid bits, stall propagation with bubble insertion, branch-redirect flushing, interrupt injection with acknowledge, and performance counters. The top level uses its per-stage load enables instead of hand-written stall/flush logic in each pipeline register. Stage count, flush depth, interrupt count and counter width are generic.

---
 rtl/pipe_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing/hazard control: run/drain/halt FSM, per-stage valid and
// halt-marker bits, stall bubbles, redirect flush, irq tagging, perf counters.

module pipe_ctrl_slot (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic hold,
  input  logic in_vld,
  input  logic in_mark,
  output logic vld,
  output logic mark
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      mark <= 1'b0;
    end else if (flush) begin
      vld  <= 1'b0;
      mark <= 1'b0;
    end else if (!hold) begin
      vld  <= in_vld;
      mark <= in_mark;
    end
  end
endmodule

module pipe_ctrl #(
  parameter int STAGES      = 5,
  parameter int FLUSH_DEPTH = 1,
  parameter int NUM_IRQ     = 2,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic               halt_fetched,
  input  logic [STAGES-1:0]  stall_req,
  input  logic               redirect,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               fetch_en,
  output logic [STAGES-1:0]  stage_en,
  output logic [STAGES-1:0]  stage_valid,
  output logic [NUM_IRQ-1:0] stage0_irq,
  output logic               irq_ack,
  output logic               halt,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   retire_cnt
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, HALTED = 2'd3} state_t;

  state_t              st_q, st_d;
  logic [STAGES-1:0]   hold, flush, vld_pipe, mark_pipe, in_vld, in_mark;
  logic [NUM_IRQ-1:0]  pend_q, grant, take;
  logic                retire, mark_out, mark_killed;

  always_comb begin
    hold = '0;
    hold[STAGES-1] = stall_req[STAGES-1];
    for (int i = STAGES-2; i >= 0; i--) hold[i] = hold[i+1] | stall_req[i];
  end

  always_comb begin
    flush = '0;
    for (int i = 0; i < FLUSH_DEPTH; i++) flush[i] = redirect;
  end

  assign fetch_en = (st_q == RUN) && !hold[0];
  assign stage_en = ~hold | flush;

  // A flushed instruction is killed, so the stage behind the flush window sees a bubble.
  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_slot
      if (g == 0) begin : g_head
        assign in_vld[g]  = fetch_en;
        assign in_mark[g] = fetch_en & halt_fetched;
      end else begin : g_body
        assign in_vld[g]  = vld_pipe[g-1] & ~hold[g-1] & ~flush[g-1];
        assign in_mark[g] = in_vld[g] & mark_pipe[g-1];
      end
      pipe_ctrl_slot u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush[g]),
        .hold    (hold[g]),
        .in_vld  (in_vld[g]),
        .in_mark (in_mark[g]),
        .vld     (vld_pipe[g]),
        .mark    (mark_pipe[g])
      );
    end
  endgenerate

  assign retire      = vld_pipe[STAGES-1] & ~hold[STAGES-1];
  assign mark_out    = retire & mark_pipe[STAGES-1];
  assign mark_killed = |(mark_pipe & vld_pipe & flush);

  // Lowest pending line wins; tag is consumed at decode so only register 0 carries it.
  assign grant = pend_q & (~pend_q + NUM_IRQ'(1));
  assign take  = fetch_en ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      stage0_irq <= '0;
    end else begin
      pend_q <= irq | (pend_q & ~take);
      if (flush[0])     stage0_irq <= '0;
      else if (!hold[0]) stage0_irq <= take;
    end
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (go) st_d = RUN;
      // a halt fetched under a same-cycle redirect is wrong-path and never enters
      RUN:     if (halt_fetched && fetch_en && !redirect) st_d = DRAIN;
      DRAIN:   if (mark_out) st_d = HALTED;
               else if (mark_killed) st_d = RUN;
      HALTED:  if (go) st_d = RUN;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= IDLE;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      st_q <= st_d;
      if ((st_q == RUN || st_q == DRAIN) && cycle_cnt != '1)
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire && retire_cnt != '1)
        retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  assign stage_valid = vld_pipe;
  assign irq_ack     = |stage0_irq;
  assign halt        = (st_q == HALTED);
  assign state       = st_q;
endmodule
